ecc_scrubber: RTL and testbench

Background ECC scrubber that walks every address of one memory-controller port, reads each word through the ECC decoder and writes the corrected data back so single-bit upsets are re-encoded clean. Uncorrectable words are left untouched and logged. It sits as a requester on one port of the ECC-enabled memory controller, driving `en/we/addr/din` and consuming the decoded `dout` and the error flag. An external arbiter's `i_busy` input makes it yield to functional traffic.

---
 rtl/ecc_scrubber.sv | 204 ++++++++++++++++++++
 tb/tb_ecc_scrubber.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_scrubber.sv
// Background ECC scrubber: walks every address, reads through the ECC decoder and writes corrected data back.
// Latency: one word per INTERVAL+1+READ_LATENCY+1+WRITE_LATENCY cycles (INTERVAL+1+READ_LATENCY if uncorrectable).
// Backpressure: i_busy holds off only the issue of a new read; an access already in flight always completes.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_enable              scrubbing enabled; a drop mid-access finishes that access then idles
//   i_busy                functional traffic owns the port; no new read issued while high
//   o_en/o_we/o_addr/o_din  request to the memory controller port (all registered)
//   i_dout/i_error        decoded read data and uncorrectable flag, valid READ_LATENCY cycles after a read
//   o_active              high in any state other than idle
//   o_err_pulse           one-cycle pulse per uncorrectable word
//   o_err_count           saturating uncorrectable-word count
//   o_last_err_addr       address of the most recent uncorrectable word
//   o_pass_done           one-cycle pulse when the last address of a pass completes
module ecc_scrubber #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 5,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 4,
  parameter int INTERVAL      = 16,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_enable,
  input  logic                     i_busy,
  output logic                     o_en,
  output logic                     o_we,
  output logic [ADDR_WIDTH-1:0]    o_addr,
  output logic [DATA_WIDTH-1:0]    o_din,
  input  logic [DATA_WIDTH-1:0]    i_dout,
  input  logic                     i_error,
  output logic                     o_active,
  output logic                     o_err_pulse,
  output logic [ERR_CNT_WIDTH-1:0] o_err_count,
  output logic [ADDR_WIDTH-1:0]    o_last_err_addr,
  output logic                     o_pass_done
);

  // One down-counter is shared by the interval wait and both latency waits,
  // so it is sized for the largest of the three.
  localparam int CNT_MAX_RW = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_MAX    = (INTERVAL > CNT_MAX_RW) ? INTERVAL : CNT_MAX_RW;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_IVL  = CNT_W'(INTERVAL);
  localparam logic [CNT_W-1:0] CNT_RLAT = CNT_W'(READ_LATENCY);
  localparam logic [CNT_W-1:0] CNT_WLAT = CNT_W'(WRITE_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_READ  = 3'd2,
    S_RWAIT = 3'd3,
    S_WRITE = 3'd4,
    S_WWAIT = 3'd5
  } state_t;

  state_t                   state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic                     en_q;
  logic                     we_q;
  logic [DATA_WIDTH-1:0]    din_q;
  logic                     active_q;
  logic                     err_pulse_q;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
  logic [ADDR_WIDTH-1:0]    last_err_q;
  logic                     pass_done_q;

  logic                     cnt_last_d;
  logic                     advance_d;
  logic [ADDR_WIDTH-1:0]    addr_inc_d;

  // A timed state is on its final cycle when the count is about to reach
  // zero; a state loaded with N therefore lasts exactly N cycles. In WAIT
  // the count then sits at zero while i_busy stalls the read.
  assign cnt_last_d = (cnt_q <= CNT_ONE);

  // A word finishes either after the write-back settles, or straight out of
  // the read wait when the decoder flagged it uncorrectable.
  assign advance_d  = cnt_last_d &&
                      ((state_q == S_WWAIT) || ((state_q == S_RWAIT) && i_error));

  assign addr_inc_d = addr_q + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      din_q       <= '0;
      active_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      last_err_q  <= '0;
      pass_done_q <= 1'b0;
    end else begin
      // Strobes and pulses are single-cycle by default.
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      err_pulse_q <= 1'b0;
      pass_done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (i_enable) begin
            state_q  <= S_WAIT;
            cnt_q    <= CNT_IVL;
            active_q <= 1'b1;
          end
        end

        S_WAIT: begin
          if (!cnt_last_d) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            cnt_q <= '0;
            if (!i_enable) begin
              state_q  <= S_IDLE;
              active_q <= 1'b0;
            end else if (!i_busy) begin
              state_q <= S_READ;
              en_q    <= 1'b1;
            end
          end
        end

        S_READ: begin
          state_q <= S_RWAIT;
          cnt_q   <= CNT_RLAT;
        end

        S_RWAIT: begin
          if (!cnt_last_d) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            din_q <= i_dout;
            if (i_error) begin
              // Leave the stored codeword alone; writing back would re-encode
              // garbage as a clean word and hide the fault.
              err_pulse_q <= 1'b1;
              last_err_q  <= addr_q;
              if (err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
              end
            end else begin
              state_q <= S_WRITE;
              en_q    <= 1'b1;
              we_q    <= 1'b1;
            end
          end
        end

        S_WRITE: begin
          state_q <= S_WWAIT;
          cnt_q   <= CNT_WLAT;
        end

        S_WWAIT: begin
          if (!cnt_last_d) begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        default: begin
          state_q  <= S_IDLE;
          cnt_q    <= '0;
          active_q <= 1'b0;
        end
      endcase

      // Word completion overrides the per-state next state chosen above.
      // i_enable is only consulted here, so a disable never cuts an access short.
      if (advance_d) begin
        addr_q      <= addr_inc_d;
        pass_done_q <= &addr_q;
        if (i_enable) begin
          state_q <= S_WAIT;
          cnt_q   <= CNT_IVL;
        end else begin
          state_q  <= S_IDLE;
          cnt_q    <= '0;
          active_q <= 1'b0;
        end
      end
    end
  end

  assign o_en            = en_q;
  assign o_we            = we_q;
  assign o_addr          = addr_q;
  assign o_din           = din_q;
  assign o_active        = active_q;
  assign o_err_pulse     = err_pulse_q;
  assign o_err_count     = err_cnt_q;
  assign o_last_err_addr = last_err_q;
  assign o_pass_done     = pass_done_q;

endmodule

// File: tb/tb_ecc_scrubber.sv
// Bench for ecc_scrubber: ECC memory model, word-timeline reference model and directed scenarios.
// Latency: checked per cycle against the reference timeline plus literal timing expectations.
// Backpressure: exercises i_busy stalls, enable drops and asynchronous reset mid-write.
module tb_ecc_scrubber;
  localparam int DW  = 8;
  localparam int AW  = 5;
  localparam int RL  = 2;
  localparam int WL  = 4;
  localparam int IV  = 4;
  localparam int ECW = 16;
  localparam int NW  = 1 << AW;
  localparam int CLEAN_LEN = IV + 1 + RL + 1 + WL;
  localparam int ERR_LEN   = IV + 1 + RL;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic           i_enable;
  logic           i_busy;
  logic           o_en;
  logic           o_we;
  logic [AW-1:0]  o_addr;
  logic [DW-1:0]  o_din;
  logic [DW-1:0]  i_dout;
  logic           i_error;
  logic           o_active;
  logic           o_err_pulse;
  logic [ECW-1:0] o_err_count;
  logic [AW-1:0]  o_last_err_addr;
  logic           o_pass_done;

  ecc_scrubber #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL),
    .WRITE_LATENCY(WL), .INTERVAL(IV), .ERR_CNT_WIDTH(ECW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_busy(i_busy),
    .o_en(o_en), .o_we(o_we), .o_addr(o_addr), .o_din(o_din),
    .i_dout(i_dout), .i_error(i_error), .o_active(o_active),
    .o_err_pulse(o_err_pulse), .o_err_count(o_err_count),
    .o_last_err_addr(o_last_err_addr), .o_pass_done(o_pass_done)
  );

  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // ECC memory: corrupt[a] 0 = clean, 1 = single-bit upset (served corrected),
  // 2 = double-bit upset (served wrong data with error flag).
  logic [DW-1:0] mem [NW];
  int            corrupt [NW];
  logic [DW-1:0] p1_dat, p2_dat;
  logic          p1_err, p2_err;
  int            cyc = 0;
  int            rd_cyc [NW];
  int            wr_cyc [NW];
  int            wr_cnt [NW];
  logic [DW-1:0] wr_dat [NW];
  int            n_rd = 0;
  int            first_rd_addr = -1;

  assign i_dout  = p2_dat;
  assign i_error = p2_err;

  function automatic logic [DW-1:0] served(input int a);
    return (corrupt[a] == 2) ? (mem[a] ^ 8'h03) : mem[a];
  endfunction

  initial begin
    p1_dat <= 8'hEE; p2_dat <= 8'hEE; p1_err <= 1'b1; p2_err <= 1'b1;
    forever begin
      @(posedge i_clk);
      cyc = cyc + 1;
      // Outside its valid slot the read port shows junk flagged as an error.
      if (o_en && !o_we) begin
        p1_dat <= served(int'(o_addr));
        p1_err <= (corrupt[o_addr] == 2);
        rd_cyc[o_addr] = cyc;
        if (n_rd == 0) first_rd_addr = int'(o_addr);
        n_rd++;
      end else begin
        p1_dat <= 8'hEE;
        p1_err <= 1'b1;
      end
      if (o_en && o_we) begin
        mem[o_addr]     = o_din;
        corrupt[o_addr] = 0;
        wr_cnt[o_addr]++;
        wr_cyc[o_addr]  = cyc;
        wr_dat[o_addr]  = o_din;
      end
      p2_dat <= p1_dat;
      p2_err <= p1_err;
    end
  end

  // Reference model: position m_p within the current word's timeline
  // (interval wait, read, read latency, [write, write latency]).
  bit            m_act = 0;
  int            m_p = 0;
  int            m_addr = 0;
  bit            m_clean = 1;
  logic [DW-1:0] m_rdata = '0;
  int            m_errcnt = 0;
  int            m_last = 0;
  bit            m_errp = 0;
  bit            m_pd = 0;

  initial begin
    forever begin
      @(posedge i_clk or posedge i_rst);
      m_errp = 0;
      m_pd   = 0;
      if (i_rst) begin
        m_act = 0; m_p = 0; m_addr = 0; m_errcnt = 0; m_last = 0; m_clean = 1;
      end else if (!m_act) begin
        if (i_enable) begin m_act = 1; m_p = 0; end
      end else if (m_p == IV - 1) begin
        if (!i_enable) m_act = 0;
        else if (!i_busy) m_p++;
      end else if (m_p == (m_clean ? CLEAN_LEN : ERR_LEN) - 1) begin
        if (!m_clean) begin
          if (m_errcnt != (1 << ECW) - 1) m_errcnt++;
          m_last = m_addr;
          m_errp = 1;
        end
        m_pd   = (m_addr == NW - 1);
        m_addr = (m_addr + 1) % NW;
        if (i_enable) m_p = 0;
        else m_act = 0;
      end else begin
        if (m_p == IV) begin
          m_clean = (corrupt[m_addr] != 2);
          m_rdata = served(m_addr);
        end
        m_p++;
      end
    end
  end

  int n_pd = 0, pd_cyc = 0, n_errp = 0;

  initial begin
    forever begin
      @(negedge i_clk);
      chk("active", 32'(o_active), 32'(m_act));
      chk("en", 32'(o_en), 32'(m_act && (m_p == IV || (m_clean && m_p == IV + RL + 1))));
      chk("we", 32'(o_we), 32'(m_act && m_clean && m_p == IV + RL + 1));
      if (m_act && m_p >= IV) chk("addr", 32'(o_addr), m_addr);
      if (m_act && m_clean && m_p >= IV + RL + 1) chk("din", 32'(o_din), 32'(m_rdata));
      chk("err_pulse", 32'(o_err_pulse), 32'(m_errp));
      chk("pass_done", 32'(o_pass_done), 32'(m_pd));
      chk("err_count", 32'(o_err_count), m_errcnt);
      chk("last_err", 32'(o_last_err_addr), m_last);
      if (o_pass_done === 1'b1) begin n_pd++; pd_cyc = cyc; end
      if (o_err_pulse === 1'b1) n_errp++;
    end
  end

  task automatic clear_logs();
    for (int a = 0; a < NW; a++) begin rd_cyc[a] = 0; wr_cyc[a] = 0; wr_cnt[a] = 0; end
    n_rd = 0;
    first_rd_addr = -1;
  endtask

  task automatic wait_wr(input int a, input int budget);
    int k = 0;
    while (wr_cnt[a] == 0 && k < budget) begin @(negedge i_clk); k++; end
    chk("timeout_wr", 32'(wr_cnt[a] != 0), 32'(1));
  endtask

  task automatic wait_rd(input int a, input int budget);
    int k = 0;
    while (rd_cyc[a] == 0 && k < budget) begin @(negedge i_clk); k++; end
    chk("timeout_rd", 32'(rd_cyc[a] != 0), 32'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"}, 32'(o_en), 0);
    chk({tag, "_we"}, 32'(o_we), 0);
    chk({tag, "_addr"}, 32'(o_addr), 0);
    chk({tag, "_din"}, 32'(o_din), 0);
    chk({tag, "_active"}, 32'(o_active), 0);
    chk({tag, "_errp"}, 32'(o_err_pulse), 0);
    chk({tag, "_errcnt"}, 32'(o_err_count), 0);
    chk({tag, "_lasterr"}, 32'(o_last_err_addr), 0);
    chk({tag, "_pd"}, 32'(o_pass_done), 0);
  endtask

  int en_cyc, mark, drop_c, k;

  initial begin
    i_rst = 1'b0; i_enable = 1'b0; i_busy = 1'b0;
    for (int a = 0; a < NW; a++) begin mem[a] = DW'(a); corrupt[a] = 0; end
    clear_logs();
    #1 i_rst = 1'b1;
    #2 chk_all_zero("reset");
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;

    // Clean pass over all 32 words.
    @(negedge i_clk);
    i_enable = 1'b1;
    en_cyc = cyc + 1;
    k = 0;
    while (n_pd == 0 && k < 500) begin @(negedge i_clk); k++; end
    chk("timeout_pass", 32'(n_pd), 1);
    chk("first_rd_lat", rd_cyc[0] - en_cyc, 5);
    chk("wr0_after_rd", wr_cyc[0] - rd_cyc[0], 3);
    chk("wr0_dat", 32'(wr_dat[0]), 0);
    chk("word_period", rd_cyc[1] - rd_cyc[0], 12);
    chk("wr31_dat", 32'(wr_dat[31]), 32'h1F);
    chk("pass_len", pd_cyc - en_cyc, 384);
    chk("errcnt_pass1", 32'(o_err_count), 0);

    // Second pass: single-bit upset at 5, double-bit upset at 9.
    clear_logs();
    corrupt[5] = 1;
    corrupt[9] = 2;
    wait_wr(10, 400);
    chk("wrap_addr", first_rd_addr, 0);
    chk("sb_wb_cnt", wr_cnt[5], 1);
    chk("sb_wb_dat", 32'(wr_dat[5]), 5);
    chk("sb_raw_clean", corrupt[5], 0);
    chk("db_no_wr", wr_cnt[9], 0);
    chk("db_raw_bad", corrupt[9], 2);
    chk("db_errcnt", 32'(o_err_count), 1);
    chk("db_last", 32'(o_last_err_addr), 9);
    chk("db_pulses", n_errp, 1);
    chk("db_gap", rd_cyc[10] - rd_cyc[9], 7);
    chk("pd_once", n_pd, 1);

    // i_busy raised during addr 10's write-back and held through the WAIT.
    i_busy = 1'b1;
    mark = n_rd;
    repeat (14) @(negedge i_clk);
    chk("busy_no_rd", n_rd - mark, 0);
    i_busy = 1'b0;
    drop_c = cyc;
    wait_rd(11, 50);
    chk("busy_release", rd_cyc[11] - drop_c, 2);

    // Asynchronous reset one cycle into addr 12's write wait.
    wait_wr(12, 100);
    @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1 chk_all_zero("midwr_rst");
    @(negedge i_clk);
    clear_logs();
    i_rst = 1'b0;
    wait_wr(3, 100);
    chk("rst_restart", first_rd_addr, 0);

    // Enable dropped in addr 3's write wait: finish, idle, resume at 4.
    i_enable = 1'b0;
    repeat (10) @(negedge i_clk);
    chk("abort_idle", 32'(o_active), 0);
    chk("abort_no_rd4", rd_cyc[4], 0);
    chk("abort_wr3", wr_cnt[3], 1);
    chk("abort_wr3_dat", 32'(wr_dat[3]), 3);
    clear_logs();
    i_enable = 1'b1;
    en_cyc = cyc + 1;
    wait_rd(4, 50);
    chk("resume_addr", first_rd_addr, 4);
    chk("resume_lat", rd_cyc[4] - en_cyc, 5);
    repeat (20) @(negedge i_clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete by t=%0t", $time);
    $fatal(1);
  end

endmodule
